// File: rtl/pc_redirect_unit.sv
// Program-counter register and next-PC selector downstream of branch_module.
// Redirects on taken BEQ/BNE, raises a one-cycle FLUSH, traps on misaligned targets.
module pc_redirect_unit #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             STALL,
    input  logic             BEQ,
    input  logic             BNE,
    input  logic [WIDTH-1:0] BR_PC,
    input  logic [WIDTH-1:0] IMM,
    output logic [WIDTH-1:0] PC,
    output logic             FETCH_VALID,
    output logic             FLUSH,
    output logic             MISALIGN,
    output logic [CNT_W-1:0] TAKEN_CNT
);

    typedef enum logic [1:0] {BOOT, RUN, REDIRECT, TRAP} state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   pc_q;
    logic               fetch_valid_q;
    logic               flush_q;
    logic               misalign_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               taken;
    logic [WIDTH-1:0]   target;
    logic [WIDTH-1:0]   pc_seq_d;
    logic [CNT_W-1:0]   cnt_d;

    assign taken    = BEQ | BNE;
    assign target   = BR_PC + IMM;
    assign pc_seq_d = STALL ? pc_q : pc_q + WIDTH'(4);
    assign cnt_d    = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            pc_q          <= RESET_VECTOR;
            fetch_valid_q <= 1'b0;
            flush_q       <= 1'b0;
            misalign_q    <= 1'b0;
            cnt_q         <= '0;
        end else begin
            case (state_q)
                BOOT: begin
                    state_q       <= RUN;
                    fetch_valid_q <= 1'b1;
                end
                RUN: begin
                    // A taken branch wins over STALL; a misaligned target wins over the redirect.
                    if (taken && (target[1:0] != 2'b00)) begin
                        state_q       <= TRAP;
                        misalign_q    <= 1'b1;
                        fetch_valid_q <= 1'b0;
                    end else if (taken) begin
                        state_q <= REDIRECT;
                        pc_q    <= target;
                        flush_q <= 1'b1;
                        cnt_q   <= cnt_d;
                    end else begin
                        pc_q <= pc_seq_d;
                    end
                end
                REDIRECT: begin
                    // BEQ/BNE here belong to a squashed instruction.
                    state_q <= RUN;
                    flush_q <= 1'b0;
                    pc_q    <= pc_seq_d;
                end
                TRAP: begin
                    flush_q       <= 1'b0;
                    fetch_valid_q <= 1'b0;
                end
                default: state_q <= BOOT;
            endcase
        end
    end

    assign PC          = pc_q;
    assign FETCH_VALID = fetch_valid_q;
    assign FLUSH       = flush_q;
    assign MISALIGN    = misalign_q;
    assign TAKEN_CNT   = cnt_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Scoreboard bench for pc_redirect_unit: driver queues hand-computed outputs,
// monitor pops and compares after every clock edge and every reset assertion.
module tb_pc_redirect_unit;

    typedef struct {
        logic [31:0] pc;
        logic        fv;
        logic        flush;
        logic        mis;
        logic [1:0]  cnt;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0;
    logic        beq = 1'b0;
    logic        bne = 1'b0;
    logic [31:0] br_pc = '0;
    logic [31:0] imm = '0;
    logic [31:0] pc;
    logic        fetch_valid;
    logic        flush;
    logic        misalign;
    logic [1:0]  taken_cnt;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    pc_redirect_unit #(
        .WIDTH(32),
        .RESET_VECTOR(32'h0000_0100),
        .CNT_W(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .STALL(stall),
        .BEQ(beq),
        .BNE(bne),
        .BR_PC(br_pc),
        .IMM(imm),
        .PC(pc),
        .FETCH_VALID(fetch_valid),
        .FLUSH(flush),
        .MISALIGN(misalign),
        .TAKEN_CNT(taken_cnt)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [31:0] p, input logic f, input logic fl,
                                input logic m, input logic [1:0] c, input string n);
        exp_t e;
        e.pc = p; e.fv = f; e.flush = fl; e.mis = m; e.cnt = c; e.name = n;
        return e;
    endfunction

    // Drive inputs now, let one rising edge sample them, then queue the expected outputs.
    task automatic step(input logic s, input logic eq, input logic ne,
                        input logic [31:0] bp, input logic [31:0] im, input exp_t e);
        stall = s; beq = eq; bne = ne; br_pc = bp; imm = im;
        @(posedge clk);
        #1 sb.push_back(e);
    endtask

    task automatic idle(input exp_t e);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, e);
    endtask

    // Assert reset mid-cycle (no clock edge), check immediately, release mid-cycle later.
    task automatic pulse_reset(input string n);
        #2 rst_n = 1'b0;
        stall = 1'b0; beq = 1'b0; bne = 1'b0;
        #1 sb.push_back(mk(32'h100, 1'b0, 1'b0, 1'b0, 2'd0, n));
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk or negedge rst_n);
            #2;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_vec++;
                if (pc !== e.pc || fetch_valid !== e.fv || flush !== e.flush ||
                    misalign !== e.mis || taken_cnt !== e.cnt) begin
                    n_bad++;
                    $display("FAIL %s: got pc=%h fv=%b flush=%b mis=%b cnt=%0d, want pc=%h fv=%b flush=%b mis=%b cnt=%0d",
                             e.name, pc, fetch_valid, flush, misalign, taken_cnt,
                             e.pc, e.fv, e.flush, e.mis, e.cnt);
                end
            end
        end
    end

    initial begin : driver
        // Power-on reset and boot sequence
        #2 rst_n = 1'b0;
        #1 sb.push_back(mk(32'h100, 1'b0, 1'b0, 1'b0, 2'd0, "reset"));
        @(posedge clk);
        #3 rst_n = 1'b1;
        idle(mk(32'h100, 1'b1, 1'b0, 1'b0, 2'd0, "boot"));
        idle(mk(32'h104, 1'b1, 1'b0, 1'b0, 2'd0, "seq1"));
        idle(mk(32'h108, 1'b1, 1'b0, 1'b0, 2'd0, "seq2"));

        // Taken BEQ backwards, BNE in REDIRECT ignored
        step(1'b0, 1'b1, 1'b0, 32'h10, 32'hFFFF_FFF8, mk(32'h08, 1'b1, 1'b1, 1'b0, 2'd1, "beq_taken"));
        step(1'b0, 1'b0, 1'b1, 32'h10, 32'h100, mk(32'h0C, 1'b1, 1'b0, 1'b0, 2'd1, "redirect_ignore"));
        idle(mk(32'h10, 1'b1, 1'b0, 1'b0, 2'd1, "after_redirect"));

        // Stall holds, branch beats stall
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, mk(32'h10, 1'b1, 1'b0, 1'b0, 2'd1, "stall1"));
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, mk(32'h10, 1'b1, 1'b0, 1'b0, 2'd1, "stall2"));
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, mk(32'h10, 1'b1, 1'b0, 1'b0, 2'd1, "stall3"));
        step(1'b1, 1'b0, 1'b1, 32'h20, 32'h40, mk(32'h60, 1'b1, 1'b1, 1'b0, 2'd2, "branch_beats_stall"));
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, mk(32'h60, 1'b1, 1'b0, 1'b0, 2'd2, "redirect_stall"));
        idle(mk(32'h64, 1'b1, 1'b0, 1'b0, 2'd2, "resume"));

        // Counter saturates at 3 after 5 taken branches
        step(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, mk(32'h100, 1'b1, 1'b1, 1'b0, 2'd3, "taken3"));
        idle(mk(32'h104, 1'b1, 1'b0, 1'b0, 2'd3, "gap3"));
        step(1'b0, 1'b1, 1'b0, 32'h200, 32'h0, mk(32'h200, 1'b1, 1'b1, 1'b0, 2'd3, "taken4_sat"));
        idle(mk(32'h204, 1'b1, 1'b0, 1'b0, 2'd3, "gap4"));
        step(1'b0, 1'b1, 1'b1, 32'h300, 32'h4, mk(32'h304, 1'b1, 1'b1, 1'b0, 2'd3, "taken5_both"));
        idle(mk(32'h308, 1'b1, 1'b0, 1'b0, 2'd3, "gap5"));

        // PC wraps modulo 2^32
        step(1'b0, 1'b1, 1'b0, 32'hFFFF_FF00, 32'hFC, mk(32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0, 2'd3, "to_top"));
        idle(mk(32'h0, 1'b1, 1'b0, 1'b0, 2'd3, "wrap"));
        idle(mk(32'h4, 1'b1, 1'b0, 1'b0, 2'd3, "post_wrap"));

        // Async reset while in REDIRECT
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h80, mk(32'h80, 1'b1, 1'b1, 1'b0, 2'd3, "pre_reset_redirect"));
        pulse_reset("async_reset_redirect");
        idle(mk(32'h100, 1'b1, 1'b0, 1'b0, 2'd0, "boot2"));
        idle(mk(32'h104, 1'b1, 1'b0, 1'b0, 2'd0, "seq3"));

        // Misaligned target traps and freezes until reset
        step(1'b0, 1'b1, 1'b0, 32'h40, 32'h4, mk(32'h44, 1'b1, 1'b1, 1'b0, 2'd1, "to_44"));
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, mk(32'h44, 1'b1, 1'b0, 1'b0, 2'd1, "hold_44"));
        step(1'b0, 1'b1, 1'b0, 32'h40, 32'h2, mk(32'h44, 1'b0, 1'b0, 1'b1, 2'd1, "misalign"));
        idle(mk(32'h44, 1'b0, 1'b0, 1'b1, 2'd1, "trap_idle"));
        step(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, mk(32'h44, 1'b0, 1'b0, 1'b1, 2'd1, "trap_branch"));
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, mk(32'h44, 1'b0, 1'b0, 1'b1, 2'd1, "trap_run"));
        pulse_reset("trap_reset");
        idle(mk(32'h100, 1'b1, 1'b0, 1'b0, 2'd0, "boot3"));

        stall = 1'b0; beq = 1'b0; bne = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected entries left unchecked, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
